// File: rtl/nmea_sentence_tx_if.sv
// Handshake bundle between the NMEA sentence transmitter and its payload source / UART sink.
// The slave modport is the transmitter's view; master is the view of whatever drives it.
interface nmea_sentence_tx_if;
    logic        i_start;
    logic [15:0] i_ti;
    logic [23:0] i_si;
    logic [7:0]  i_data;
    logic        i_data_valid;
    logic        i_data_last;
    logic        o_data_ready;
    logic [7:0]  o_char;
    logic        o_char_valid;
    logic        i_char_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_checksum;
    logic [7:0]  o_fieldcnt;

    modport slave (
        input  i_start, i_ti, i_si, i_data, i_data_valid, i_data_last, i_char_ready,
        output o_data_ready, o_char, o_char_valid, o_busy, o_done, o_err, o_checksum, o_fieldcnt
    );

    modport master (
        output i_start, i_ti, i_si, i_data, i_data_valid, i_data_last, i_char_ready,
        input  o_data_ready, o_char, o_char_valid, o_busy, o_done, o_err, o_checksum, o_fieldcnt
    );
endinterface

// File: rtl/nmea_sentence_tx.sv
// Emits one NMEA-0183 sentence "$" TI SI "," data "*" HH CR LF as a valid/ready byte stream,
// accumulating the XOR checksum on the fly and appending it as uppercase hex.
module nmea_sentence_tx #(
    parameter int MAX_DATA = 70
) (
    input  logic               i_clk,
    input  logic               i_rst,
    nmea_sentence_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_DATA + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_DOLLAR = 4'd1;
    localparam logic [3:0] ST_TI0    = 4'd2;
    localparam logic [3:0] ST_TI1    = 4'd3;
    localparam logic [3:0] ST_SI0    = 4'd4;
    localparam logic [3:0] ST_SI1    = 4'd5;
    localparam logic [3:0] ST_SI2    = 4'd6;
    localparam logic [3:0] ST_COMMA  = 4'd7;
    localparam logic [3:0] ST_DATA   = 4'd8;
    localparam logic [3:0] ST_DROP   = 4'd9;
    localparam logic [3:0] ST_STAR   = 4'd10;
    localparam logic [3:0] ST_HEXH   = 4'd11;
    localparam logic [3:0] ST_HEXL   = 4'd12;
    localparam logic [3:0] ST_CR     = 4'd13;
    localparam logic [3:0] ST_LF     = 4'd14;

    logic [3:0]       state;
    logic [7:0]       char_p0;
    logic             char_vld_p0;
    logic [7:0]       csum;
    logic [7:0]       fieldcnt;
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic             star_loaded;
    logic [15:0]      ti_q;
    logic [23:0]      si_q;

    logic xfer, slot_free, data_ready, accept;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_illegal(input logic [7:0] b);
        return (b == 8'h24) || (b == 8'h2A) || (b == 8'h0D) || (b == 8'h0A);
    endfunction

    assign xfer       = char_vld_p0 && bus.i_char_ready;
    assign slot_free  = !char_vld_p0 || bus.i_char_ready;
    assign data_ready = ((state == ST_DATA) || (state == ST_DROP)) && slot_free;
    assign accept     = data_ready && bus.i_data_valid;

    assign bus.o_data_ready = data_ready;
    assign bus.o_char       = char_p0;
    assign bus.o_char_valid = char_vld_p0;
    assign bus.o_busy       = (state != ST_IDLE);
    assign bus.o_done       = (state == ST_LF) && xfer;
    assign bus.o_err        = err;
    assign bus.o_checksum   = csum;
    assign bus.o_fieldcnt   = fieldcnt;

    // Fixed-character states hold their own char in the output slot and move on when it transfers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            char_p0     <= 8'h00;
            char_vld_p0 <= 1'b0;
            csum        <= 8'h00;
            fieldcnt    <= 8'h00;
            err         <= 1'b0;
            cnt         <= '0;
            star_loaded <= 1'b0;
            ti_q        <= 16'h0000;
            si_q        <= 24'h000000;
        end else begin
            case (state)
                ST_IDLE: if (bus.i_start) begin
                    ti_q        <= bus.i_ti;
                    si_q        <= bus.i_si;
                    csum        <= 8'h00;
                    err         <= 1'b0;
                    fieldcnt    <= 8'd1;
                    cnt         <= '0;
                    char_p0     <= 8'h24;
                    char_vld_p0 <= 1'b1;
                    state       <= ST_DOLLAR;
                end
                ST_DOLLAR: if (xfer) begin
                    char_p0 <= ti_q[7:0];
                    csum    <= csum ^ ti_q[7:0];
                    state   <= ST_TI0;
                end
                ST_TI0: if (xfer) begin
                    char_p0 <= ti_q[15:8];
                    csum    <= csum ^ ti_q[15:8];
                    state   <= ST_TI1;
                end
                ST_TI1: if (xfer) begin
                    char_p0 <= si_q[7:0];
                    csum    <= csum ^ si_q[7:0];
                    state   <= ST_SI0;
                end
                ST_SI0: if (xfer) begin
                    char_p0 <= si_q[15:8];
                    csum    <= csum ^ si_q[15:8];
                    state   <= ST_SI1;
                end
                ST_SI1: if (xfer) begin
                    char_p0 <= si_q[23:16];
                    csum    <= csum ^ si_q[23:16];
                    state   <= ST_SI2;
                end
                ST_SI2: if (xfer) begin
                    char_p0 <= 8'h2C;
                    csum    <= csum ^ 8'h2C;
                    state   <= ST_COMMA;
                end
                ST_COMMA: if (xfer) begin
                    char_vld_p0 <= 1'b0;
                    state       <= ST_DATA;
                end
                ST_DATA: begin
                    if (xfer) char_vld_p0 <= 1'b0;
                    if (accept) begin
                        if (is_illegal(bus.i_data)) begin
                            err <= 1'b1;
                        end else if (cnt == MAX_CNT) begin
                            err   <= 1'b1;
                            state <= ST_DROP;
                        end else begin
                            char_p0     <= bus.i_data;
                            char_vld_p0 <= 1'b1;
                            csum        <= csum ^ bus.i_data;
                            cnt         <= cnt + 1'b1;
                            if (bus.i_data == 8'h2C) fieldcnt <= sat_inc(fieldcnt);
                        end
                        if (bus.i_data_last) begin
                            state       <= ST_STAR;
                            star_loaded <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (xfer) char_vld_p0 <= 1'b0;
                    if (accept && bus.i_data_last) begin
                        state       <= ST_STAR;
                        star_loaded <= 1'b0;
                    end
                end
                // First free slot takes '*'; the '*' transfer then loads the high hex digit.
                ST_STAR: if (slot_free) begin
                    if (!star_loaded) begin
                        char_p0     <= 8'h2A;
                        char_vld_p0 <= 1'b1;
                        star_loaded <= 1'b1;
                    end else begin
                        char_p0 <= hex_char(csum[7:4]);
                        state   <= ST_HEXH;
                    end
                end
                ST_HEXH: if (xfer) begin
                    char_p0 <= hex_char(csum[3:0]);
                    state   <= ST_HEXL;
                end
                ST_HEXL: if (xfer) begin
                    char_p0 <= 8'h0D;
                    state   <= ST_CR;
                end
                ST_CR: if (xfer) begin
                    char_p0 <= 8'h0A;
                    state   <= ST_LF;
                end
                ST_LF: if (xfer) begin
                    char_vld_p0 <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_sentence_tx.sv
// Directed bench for nmea_sentence_tx: table of sentences with hand-computed streams,
// plus a mid-sentence reset sequence.
module tb_nmea_sentence_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    nmea_sentence_tx_if bus();

    nmea_sentence_tx #(.MAX_DATA(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] ti;
        logic [23:0] si;
        string       pay;
        int          mode;   // 0: always ready, 1: 5-cycle stall on '*' + gapped data, 2: alternating ready + gapped data
        string       exp;
        logic [7:0]  csum;
        logic [7:0]  fc;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v);
        string got;
        int    idx, dones, stall_left, len;
        bit    held, seen_done;
        logic [7:0] held_c;
        got = ""; idx = 0; dones = 0; held = 1'b0; seen_done = 1'b0; held_c = 8'h00;
        stall_left = (v.mode == 1) ? 5 : 0;
        len = v.pay.len();
        @(negedge clk);
        bus.i_ti = v.ti;
        bus.i_si = v.si;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check({v.name, "/dollar"}, {23'h0, bus.o_char_valid, bus.o_char}, {23'h0, 1'b1, 8'h24});
        check({v.name, "/start_err"}, {31'h0, bus.o_err}, 32'h0);
        check({v.name, "/start_fc"}, {24'h0, bus.o_fieldcnt}, 32'h1);
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (v.mode == 1) begin
                if (bus.o_char_valid && bus.o_char == 8'h2A && stall_left > 0) begin
                    bus.i_char_ready = 1'b0;
                    stall_left--;
                end else bus.i_char_ready = 1'b1;
            end else if (v.mode == 2) bus.i_char_ready = (cyc % 2) == 0;
            else bus.i_char_ready = 1'b1;
            if (idx < len && (v.mode == 0 || (cyc % 3) != 1)) begin
                bus.i_data_valid = 1'b1;
                bus.i_data = v.pay[idx];
                bus.i_data_last = (idx == len - 1);
            end else begin
                bus.i_data_valid = 1'b0;
                bus.i_data = 8'h00;
                bus.i_data_last = 1'b0;
            end
            #1;
            if (held) begin
                check({v.name, "/held"}, {23'h0, bus.o_char_valid, bus.o_char}, {23'h0, 1'b1, held_c});
                held = 1'b0;
            end
            if (bus.o_char_valid && !bus.i_char_ready) begin
                check({v.name, "/blocked_ready"}, {31'h0, bus.o_data_ready}, 32'h0);
                held = 1'b1;
                held_c = bus.o_char;
            end
            if (bus.o_char_valid && bus.i_char_ready) got = $sformatf("%s%c", got, bus.o_char);
            if (bus.i_data_valid && bus.o_data_ready) idx++;
            if (bus.o_done) begin
                dones++;
                seen_done = 1'b1;
            end
            @(negedge clk);
        end
        bus.i_data_valid = 1'b0;
        bus.i_char_ready = 1'b1;
        n_checks++;
        if (got != v.exp) begin
            n_fail++;
            $display("FAIL %s/stream: got %0d chars ending 0x%0h, required %0d chars",
                     v.name, got.len(), (got.len() > 2) ? got[got.len()-3] : 8'h00, v.exp.len());
        end
        check({v.name, "/consumed"}, idx, len);
        check({v.name, "/done_pulses"}, dones, 1);
        check({v.name, "/busy_after"}, {30'h0, bus.o_busy, bus.o_done}, 32'h0);
        check({v.name, "/checksum"}, {24'h0, bus.o_checksum}, {24'h0, v.csum});
        check({v.name, "/fieldcnt"}, {24'h0, bus.o_fieldcnt}, {24'h0, v.fc});
        check({v.name, "/err"}, {31'h0, bus.o_err}, {31'h0, v.err});
    endtask

    initial begin
        vecs[0] = '{"basic",    16'h5047, 24'h414141, "1",       0, "$GPAAA,1*4B\r\n",    8'h4B, 8'd1, 1'b0};
        vecs[1] = '{"multi",    16'h5047, 24'h414141, "1,2",     0, "$GPAAA,1,2*55\r\n",  8'h55, 8'd2, 1'b0};
        vecs[2] = '{"bp_star",  16'h5047, 24'h414141, "1",       1, "$GPAAA,1*4B\r\n",    8'h4B, 8'd1, 1'b0};
        vecs[3] = '{"illegal",  16'h5047, 24'h414141, "1*2",     0, "$GPAAA,12*79\r\n",   8'h79, 8'd1, 1'b1};
        vecs[4] = '{"ovf5",     16'h5047, 24'h414141, "12345",   0, "$GPAAA,1234*7E\r\n", 8'h7E, 8'd1, 1'b1};
        vecs[5] = '{"ovf7",     16'h5047, 24'h414141, "1234567", 0, "$GPAAA,1234*7E\r\n", 8'h7E, 8'd1, 1'b1};
        vecs[6] = '{"exact4",   16'h5047, 24'h414141, "1234",    0, "$GPAAA,1234*7E\r\n", 8'h7E, 8'd1, 1'b0};
        vecs[7] = '{"bp_alt",   16'h5047, 24'h414141, "1,2",     2, "$GPAAA,1,2*55\r\n",  8'h55, 8'd2, 1'b0};
        vecs[8] = '{"ill_last", 16'h5047, 24'h414141, "*",       0, "$GPAAA,*7A\r\n",     8'h7A, 8'd1, 1'b1};
        vecs[9] = '{"xdr",      16'h4949, 24'h524458, "A,B",     0, "$IIXDR,A,B*4D\r\n",  8'h4D, 8'd2, 1'b0};

        bus.i_start = 1'b0; bus.i_ti = 16'h0; bus.i_si = 24'h0;
        bus.i_data = 8'h0; bus.i_data_valid = 1'b0; bus.i_data_last = 1'b0;
        bus.i_char_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus.o_char, bus.o_checksum, bus.o_fieldcnt, 3'b0, bus.o_char_valid, bus.o_busy, bus.o_done, bus.o_err, bus.o_data_ready},
              32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {29'h0, bus.o_busy, bus.o_char_valid, bus.o_data_ready}, 32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Mid-sentence reset while 'P' is on the output.
        begin
            bit seen_p;
            bit any_done;
            seen_p = 1'b0;
            any_done = 1'b0;
            @(negedge clk);
            bus.i_ti = 16'h5047; bus.i_si = 24'h414141; bus.i_start = 1'b1;
            @(negedge clk);
            bus.i_start = 1'b0;
            for (int c = 0; c < 20 && !seen_p; c++) begin
                if (bus.o_char_valid && bus.o_char == 8'h50) seen_p = 1'b1;
                else @(negedge clk);
            end
            check("rst_saw_P", {31'h0, seen_p}, 32'h1);
            #2 rst = 1'b1;
            #1;
            check("rst_async_clear", {bus.o_char, 5'h0, bus.o_char_valid, bus.o_busy, bus.o_done}, 32'h0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (bus.o_done) any_done = 1'b1;
            end
            check("rst_no_done", {31'h0, any_done}, 32'h0);
            rst = 1'b0;
            run_vec(vecs[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
